alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core_pkg.sv | 36 +++
 rtl/alu_addsub.sv | 27 ++
 rtl/alu_core.sv | 109 ++++++++++
 tb/tb_alu_core.sv | 87 ++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// alu_core_pkg: shared constants for the ALU core.
//   - OP_* : operation class selects (2 bits)
//   - OPC_*: data-processing opcodes (4 bits)
//   - FLAG_*: bit positions inside the {N,Z,C,V} flag vector
package alu_core_pkg;

  localparam int W = 32;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [3:0] OPC_AND = 4'd0;
  localparam logic [3:0] OPC_EOR = 4'd1;
  localparam logic [3:0] OPC_SUB = 4'd2;
  localparam logic [3:0] OPC_RSB = 4'd3;
  localparam logic [3:0] OPC_ADD = 4'd4;
  localparam logic [3:0] OPC_ADC = 4'd5;
  localparam logic [3:0] OPC_SBC = 4'd6;
  localparam logic [3:0] OPC_RSC = 4'd7;
  localparam logic [3:0] OPC_TST = 4'd8;
  localparam logic [3:0] OPC_TEQ = 4'd9;
  localparam logic [3:0] OPC_CMP = 4'd10;
  localparam logic [3:0] OPC_CMN = 4'd11;
  localparam logic [3:0] OPC_ORR = 4'd12;
  localparam logic [3:0] OPC_MOV = 4'd13;
  localparam logic [3:0] OPC_BIC = 4'd14;
  localparam logic [3:0] OPC_MVN = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: 32-bit adder with carry-in. Subtraction is done by the caller
// feeding an inverted operand and cin=1 (or cin=C for borrow chains).
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (mod 2^32)
//   cout : carry out of bit 31
//   ovf  : two's-complement signed overflow
module alu_addsub
  import alu_core_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];
  // Overflow when both operands share a sign that the result does not.
  assign ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/alu_core.sv
// alu_core: single-cycle ALU with registered result and {N,Z,C,V} flags.
//   clk, rst_n : clock, synchronous active-low reset
//   Aport      : operand A
//   Bport      : operand B / offset
//   OP         : class (data-proc, mem address, branch target, reserved)
//   cmd        : DP opcode; cmd[3] is the offset direction for mem address
//   ALU_out    : registered result (1 cycle latency)
//   flags      : registered {N,Z,C,V}
module alu_core
  import alu_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] Aport,
  input  logic [W-1:0] Bport,
  input  logic [1:0]   OP,
  input  logic [3:0]   cmd,
  output logic [W-1:0] ALU_out,
  output logic [3:0]   flags
);

  logic [W-1:0] add_x, add_y, add_b, add_sum;
  logic         add_inv, add_cin, add_cout, add_ovf;
  logic [W-1:0] res;
  logic         arith;
  logic [3:0]   nflags;
  logic         c_reg;

  assign c_reg = flags[FLAG_C];

  // Every arithmetic path shares one adder: operands may be swapped
  // (reverse subtracts) and the second one inverted (subtraction).
  assign add_b = add_inv ? ~add_y : add_y;

  alu_addsub u_addsub (
    .a    (add_x),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  always_comb begin
    add_x   = Aport;
    add_y   = Bport;
    add_inv = 1'b0;
    add_cin = 1'b0;
    res     = '0;
    arith   = 1'b0;
    case (OP)
      OP_DP: begin
        case (cmd)
          OPC_AND, OPC_TST: res = Aport & Bport;
          OPC_EOR, OPC_TEQ: res = Aport ^ Bport;
          OPC_SUB, OPC_CMP: begin add_inv = 1'b1; add_cin = 1'b1; arith = 1'b1; res = add_sum; end
          OPC_RSB: begin
            add_x = Bport; add_y = Aport; add_inv = 1'b1; add_cin = 1'b1;
            arith = 1'b1; res = add_sum;
          end
          OPC_ADD, OPC_CMN: begin arith = 1'b1; res = add_sum; end
          OPC_ADC: begin add_cin = c_reg; arith = 1'b1; res = add_sum; end
          OPC_SBC: begin add_inv = 1'b1; add_cin = c_reg; arith = 1'b1; res = add_sum; end
          OPC_RSC: begin
            add_x = Bport; add_y = Aport; add_inv = 1'b1; add_cin = c_reg;
            arith = 1'b1; res = add_sum;
          end
          OPC_ORR: res = Aport | Bport;
          OPC_MOV: res = Bport;
          OPC_BIC: res = Aport & ~Bport;
          OPC_MVN: res = ~Bport;
          default: res = '0;
        endcase
      end
      OP_MEM: begin
        // U bit clear means subtract the offset.
        add_inv = ~cmd[3];
        add_cin = ~cmd[3];
        res     = add_sum;
      end
      OP_BR:   res = add_sum;
      default: res = '0;
    endcase
  end

  // Only data-processing touches flags; logical ops keep C and V.
  always_comb begin
    nflags = flags;
    if (OP == OP_DP) begin
      nflags[FLAG_N] = res[W-1];
      nflags[FLAG_Z] = (res == '0);
      if (arith) begin
        nflags[FLAG_C] = add_cout;
        nflags[FLAG_V] = add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_out <= '0;
      flags   <= 4'h0;
    end else begin
      ALU_out <= res;
      flags   <= nflags;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors with hand-computed results for alu_core.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Aport, Bport;
  logic [1:0]  OP;
  logic [3:0]  cmd;
  logic [31:0] ALU_out;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Aport   (Aport),
    .Bport   (Bport),
    .OP      (OP),
    .cmd     (cmd),
    .ALU_out (ALU_out),
    .flags   (flags)
  );

  // Apply one operation, clock it, then check result and flags 1ns later.
  task automatic step(input string tag, input logic rst, input logic [1:0] op,
                      input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_out, input logic [3:0] exp_flg);
    rst_n = rst; OP = op; cmd = c; Aport = a; Bport = b;
    @(posedge clk);
    #1;
    n_cmp++;
    assert (ALU_out === exp_out) else begin
      n_err++;
      $error("FAIL %s out: got %h want %h", tag, ALU_out, exp_out);
    end
    n_cmp++;
    assert (flags === exp_flg) else begin
      n_err++;
      $error("FAIL %s flags: got %b want %b", tag, flags, exp_flg);
    end
  endtask

  initial begin
    rst_n = 1'b0; OP = 2'd0; cmd = 4'd0; Aport = '0; Bport = '0;
    @(negedge clk);
    //    tag        rst  OP    cmd    A             B             out           NZCV
    step("reset",    0, 2'd0, 4'd4,  32'd5,        32'd5,        32'h0,        4'b0000);
    step("eor",      1, 2'd0, 4'd1,  32'h00011111, 32'd1,        32'h00011110, 4'b0000);
    step("sub",      1, 2'd0, 4'd2,  32'h00011111, 32'd1,        32'h00011110, 4'b0010);
    step("add",      1, 2'd0, 4'd4,  32'h00011111, 32'd1,        32'h00011112, 4'b0000);
    step("orr",      1, 2'd0, 4'd12, 32'h00011111, 32'd1,        32'h00011111, 4'b0000);
    step("rsb",      1, 2'd0, 4'd3,  32'h00011111, 32'd1,        32'hFFFEEEF0, 4'b1000);
    step("cmp",      1, 2'd0, 4'd10, 32'h00011111, 32'd1,        32'h00011110, 4'b0010);
    step("adc_c1",   1, 2'd0, 4'd5,  32'd1,        32'd2,        32'd4,        4'b0000);
    step("sbc_c0",   1, 2'd0, 4'd6,  32'd10,       32'd3,        32'd6,        4'b0010);
    step("rsc_c1",   1, 2'd0, 4'd7,  32'd3,        32'd10,       32'd7,        4'b0010);
    step("mem_sub",  1, 2'd1, 4'd0,  32'd15,       32'd14,       32'd1,        4'b0010);
    step("mem_add",  1, 2'd1, 4'd8,  32'd15,       32'd14,       32'd29,       4'b0010);
    step("branch",   1, 2'd2, 4'd0,  32'hFFFFFFFF, 32'd20,       32'h00000013, 4'b0010);
    step("reserved", 1, 2'd3, 4'd4,  32'd1,        32'd2,        32'h0,        4'b0010);
    step("add_ovf",  1, 2'd0, 4'd4,  32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001);
    step("adc_zero", 1, 2'd0, 4'd5,  32'd0,        32'd0,        32'h0,        4'b0100);
    step("cmn_cv",   1, 2'd0, 4'd11, 32'h80000000, 32'h80000000, 32'h0,        4'b0111);
    step("bic",      1, 2'd0, 4'd14, 32'h0000F0F0, 32'h000000F0, 32'h0000F000, 4'b0011);
    step("mvn",      1, 2'd0, 4'd15, 32'd7,        32'd0,        32'hFFFFFFFF, 4'b1011);
    step("tst",      1, 2'd0, 4'd8,  32'h000000F0, 32'h0000000F, 32'h0,        4'b0111);
    step("teq",      1, 2'd0, 4'd9,  32'd5,        32'd3,        32'd6,        4'b0011);
    step("mov",      1, 2'd0, 4'd13, 32'd9,        32'h12345678, 32'h12345678, 4'b0011);
    step("and",      1, 2'd0, 4'd0,  32'hFF00FF00, 32'hF0F0F0F0, 32'hF000F000, 4'b1011);
    step("mid_rst",  0, 2'd0, 4'd4,  32'd1,        32'd1,        32'h0,        4'b0000);
    step("post_adc", 1, 2'd0, 4'd5,  32'd5,        32'd6,        32'd11,       4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the clock or the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
